// File: rtl/sampler_trigger_ctrl.sv
// rtl/sampler_trigger_ctrl.sv - arm/trigger/delay/capture sequencer for one sampler buffer
module sampler_trigger_ctrl #(
  parameter int width     = 32,
  parameter int delayBits = 16,
  parameter int countBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [width-1:0]     trig_mask,
  input  logic [width-1:0]     trig_value,
  input  logic                 trig_edge,
  input  logic [delayBits-1:0] trig_delay,
  input  logic [width-1:0]     in,
  input  logic                 w_done,
  output logic                 w_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 done_pulse,
  output logic [countBits-1:0] capture_count,
  output logic [31:0]          wait_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  logic [width-1:0]     r_mask_q;
  logic [width-1:0]     r_value_q;
  logic                 r_edge_q;
  logic [delayBits-1:0] r_delay_q;
  logic [delayBits-1:0] r_cnt;
  logic                 r_prev_match;

  logic w_match;
  logic w_fire;

  // Masked compare of the live word; an all-zero mask matches every word.
  // Edge mode fires only when the match appears, not while it persists.
  assign w_match = (((in ^ r_value_q) & r_mask_q) == '0);
  assign w_fire  = r_edge_q ? (w_match & ~r_prev_match) : w_match;

  // Sequencer state, latched trigger config and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mask_q      <= '0;
      r_value_q     <= '0;
      r_edge_q      <= 1'b0;
      r_delay_q     <= '0;
      r_cnt         <= '0;
      r_prev_match  <= 1'b0;
      w_reset_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      done_pulse    <= 1'b0;
      capture_count <= '0;
      wait_cycles   <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (abort) begin
        // Abort wins over arm, fire and w_done; it is a no-op when idle
        // but still suppresses a coincident arm.
        if (r_state != S_IDLE) begin
          r_state   <= S_IDLE;
          w_reset_n <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            // From DONE the buffer stays frozen until a new arm arrives.
            if (arm) begin
              r_mask_q     <= trig_mask;
              r_value_q    <= trig_value;
              r_edge_q     <= trig_edge;
              r_delay_q    <= trig_delay;
              r_prev_match <= 1'b1;
              wait_cycles  <= '0;
              r_state      <= S_ARMED;
              w_reset_n    <= 1'b0;
              busy         <= 1'b1;
              done         <= 1'b0;
            end
          end
          S_ARMED: begin
            if (wait_cycles != 32'hFFFF_FFFF) begin
              wait_cycles <= wait_cycles + 32'd1;
            end
            r_prev_match <= w_match;
            if (w_fire) begin
              if (r_delay_q == '0) begin
                r_state   <= S_CAPTURE;
                w_reset_n <= 1'b1;
              end else begin
                r_cnt   <= r_delay_q;
                r_state <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            // Loaded with delay_q, leaving at 1 gives exactly delay_q cycles here.
            r_cnt <= r_cnt - delayBits'(1);
            if (r_cnt == delayBits'(1)) begin
              r_state   <= S_CAPTURE;
              w_reset_n <= 1'b1;
            end
          end
          S_CAPTURE: begin
            if (w_done) begin
              r_state       <= S_DONE;
              done_pulse    <= 1'b1;
              capture_count <= capture_count + countBits'(1);
              busy          <= 1'b0;
              done          <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            w_reset_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sampler_trigger_ctrl.sv
// tb/tb_sampler_trigger_ctrl.sv - self-checking bench for sampler_trigger_ctrl
module tb_sampler_trigger_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic        trig_edge;
  logic [15:0] trig_delay;
  logic [31:0] din;
  logic        w_done;
  logic        w_reset_n;
  logic        busy;
  logic        done;
  logic        done_pulse;
  logic [1:0]  capture_count;
  logic [31:0] wait_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sampler_trigger_ctrl #(
    .width(32),
    .delayBits(16),
    .countBits(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arm(arm),
    .abort(abort),
    .trig_mask(trig_mask),
    .trig_value(trig_value),
    .trig_edge(trig_edge),
    .trig_delay(trig_delay),
    .in(din),
    .w_done(w_done),
    .w_reset_n(w_reset_n),
    .busy(busy),
    .done(done),
    .done_pulse(done_pulse),
    .capture_count(capture_count),
    .wait_cycles(wait_cycles)
  );

  typedef struct {
    logic        rst;
    logic        arm;
    logic        abort;
    logic [31:0] mask;
    logic [31:0] value;
    logic        edg;
    logic [15:0] delay;
    logic [31:0] din;
    logic        wd;
    logic        e_wrn;
    logic        e_busy;
    logic        e_done;
    logic        e_pulse;
    logic [31:0] e_cnt;
    logic [31:0] e_wait;
    logic        ck_wait;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  logic        g_rst   = 1'b0;
  logic [31:0] g_mask  = 32'h0;
  logic [31:0] g_value = 32'h0;
  logic        g_edge  = 1'b0;
  logic [15:0] g_delay = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected right after the edge; wt<0 skips wait_cycles.
  task automatic add(input logic a, input logic ab, input logic [31:0] x, input logic wd,
                     input logic wrn, input logic bsy, input logic dn, input logic pl,
                     input int cnt, input int wt);
    vec_t t;
    t.rst = g_rst; t.arm = a; t.abort = ab;
    t.mask = g_mask; t.value = g_value; t.edg = g_edge; t.delay = g_delay;
    t.din = x; t.wd = wd;
    t.e_wrn = wrn; t.e_busy = bsy; t.e_done = dn; t.e_pulse = pl;
    t.e_cnt = 32'(cnt);
    t.e_wait = (wt < 0) ? 32'h0 : 32'(wt);
    t.ck_wait = (wt >= 0);
    vecs.push_back(t);
  endtask

  task automatic step(input vec_t t, input string tag);
    vec_t e;
    reset = t.rst; arm = t.arm; abort = t.abort;
    trig_mask = t.mask; trig_value = t.value; trig_edge = t.edg; trig_delay = t.delay;
    din = t.din; w_done = t.wd;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, " w_reset_n"}, 32'(w_reset_n), 32'(e.e_wrn));
    check({tag, " busy"}, 32'(busy), 32'(e.e_busy));
    check({tag, " done"}, 32'(done), 32'(e.e_done));
    check({tag, " done_pulse"}, 32'(done_pulse), 32'(e.e_pulse));
    check({tag, " capture_count"}, 32'(capture_count), e.e_cnt);
    if (e.ck_wait) check({tag, " wait_cycles"}, wait_cycles, e.e_wait);
  endtask

  task automatic run_table(input string sec);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("%s[%0d]", sec, i));
    end
    vecs.delete();
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0;
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'h1234; trig_edge = 1'b1; trig_delay = 16'h7;
    din = 32'h0; w_done = 1'b0;

    // Reset state, with arm asserted during reset to show it is ignored.
    g_rst = 1'b1;
    add(1, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
    run_table("reset");
    g_rst = 1'b0;

    // 1: level trigger, no delay
    g_mask = 32'hFF; g_value = 32'h5A; g_edge = 1'b0; g_delay = 16'd0;
    add(1, 0, 32'h00, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 1);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 2);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 3);
    add(0, 0, 32'h5A, 0,  1, 1, 0, 0, 0, 4);
    add(0, 0, 32'h5A, 0,  1, 1, 0, 0, 0, 4);
    add(0, 0, 32'h00, 1,  1, 0, 1, 1, 1, 4);
    add(0, 0, 32'h00, 0,  1, 0, 1, 0, 1, 4);
    run_table("level");

    // 2: edge trigger with the input already matching at arm
    g_edge = 1'b1;
    add(1, 0, 32'h5A, 0,  0, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 32'h5A, 0,  0, 1, 0, 0, 1, k);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 1, 6);
    add(0, 0, 32'h5A, 0,  1, 1, 0, 0, 1, 7);
    add(1, 0, 32'h5A, 0,  1, 1, 0, 0, 1, 7);
    add(0, 0, 32'h5A, 1,  1, 0, 1, 1, 2, 7);
    run_table("edge");

    // 3: delay of 3 with mask 0; an arm with altered config during DELAY is ignored
    g_mask = 32'h0; g_edge = 1'b0; g_delay = 16'd3;
    add(1, 0, 32'h33, 0,  0, 1, 0, 0, 2, 0);
    add(0, 0, 32'h33, 0,  0, 1, 0, 0, 2, 1);
    g_delay = 16'd0; g_mask = 32'hFFFF_FFFF;
    add(1, 0, 32'h44, 0,  0, 1, 0, 0, 2, 1);
    add(0, 0, 32'h44, 0,  0, 1, 0, 0, 2, 1);
    add(0, 0, 32'h44, 0,  1, 1, 0, 0, 2, 1);
    add(0, 0, 32'h44, 1,  1, 0, 1, 1, 3, 1);
    run_table("delay");

    // 4: abort in CAPTURE (with w_done), abort in IDLE, abort+arm in ARMED and DONE
    g_mask = 32'h0; g_delay = 16'd0;
    add(1, 0, 32'h0, 0,  0, 1, 0, 0, 3, 0);
    add(0, 0, 32'h0, 0,  1, 1, 0, 0, 3, 1);
    add(0, 1, 32'h0, 1,  0, 0, 0, 0, 3, -1);
    add(0, 1, 32'h0, 0,  0, 0, 0, 0, 3, -1);
    add(1, 0, 32'h0, 0,  0, 1, 0, 0, 3, 0);
    add(1, 1, 32'h0, 0,  0, 0, 0, 0, 3, -1);
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 3, -1);
    add(1, 0, 32'h0, 0,  0, 1, 0, 0, 3, 0);
    add(0, 0, 32'h0, 0,  1, 1, 0, 0, 3, 1);
    add(0, 0, 32'h0, 1,  1, 0, 1, 1, 0, 1);
    add(1, 1, 32'h0, 0,  0, 0, 0, 0, 0, -1);
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 0, -1);
    run_table("abort");

    // 5: re-arm from DONE with a new value; only the new value fires
    g_mask = 32'hFF; g_value = 32'h22;
    add(1, 0, 32'h00, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 32'h22, 0,  1, 1, 0, 0, 0, 1);
    add(0, 0, 32'h22, 1,  1, 0, 1, 1, 1, 1);
    add(0, 0, 32'h22, 0,  1, 0, 1, 0, 1, 1);
    g_value = 32'h11;
    add(1, 0, 32'h22, 0,  0, 1, 0, 0, 1, 0);
    add(0, 0, 32'h22, 0,  0, 1, 0, 0, 1, 1);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 1, 2);
    add(0, 0, 32'h11, 0,  1, 1, 0, 0, 1, 3);
    add(0, 0, 32'h11, 1,  1, 0, 1, 1, 2, 3);
    run_table("rearm");

    // 6: hand-written sequence, reset while in DELAY with cnt=2, then a normal capture
    g_mask = 32'h0; g_delay = 16'd3; g_edge = 1'b0;
    add(1, 0, 32'h0, 0,  0, 1, 0, 0, 2, 0);
    add(0, 0, 32'h0, 0,  0, 1, 0, 0, 2, 1);
    add(0, 0, 32'h0, 0,  0, 1, 0, 0, 2, 1);
    g_rst = 1'b1;
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
    g_rst = 1'b0;
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
    g_mask = 32'hFF; g_value = 32'h5A; g_delay = 16'd0;
    add(1, 0, 32'h00, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 1);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 2);
    add(0, 0, 32'h00, 0,  0, 1, 0, 0, 0, 3);
    add(0, 0, 32'h5A, 0,  1, 1, 0, 0, 0, 4);
    add(0, 0, 32'h5A, 1,  1, 0, 1, 1, 1, 4);
    run_table("rst_delay");

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
